// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Load/store front end for a 64-bit, byte-addressed, little-endian data
//   memory that only supports full 64-bit writes. It turns byte, half, word
//   and double requests into memory transactions. Partial stores use
//   read-modify-write. Loads are sign- or zero-extended. Each request ends
//   with a one-cycle completion pulse.
//
//   Optional build macro: MEM_ACCESS_ADDR_CHECK_EN
//     When it is defined, out-of-range requests finish with resp_error.
//     When it is undefined, resp_error is always 0.
//
// Parameters
//   MEM_RD_LAT    cycles from a stable mem_raddress to valid mem_data_out (1-4)
//   ADDR_BITS     implemented memory address bits (used only by the range check)
//
// Ports
//   clk, rst_n            clock; synchronous active-low reset
//   req_valid/req_ready   request handshake (ready only in IDLE, outside reset)
//   req_write             1 = store, 0 = load
//   req_size              00 byte, 01 half, 10 word, 11 double
//   req_unsigned          zero-extend loads
//   req_addr, req_wdata   byte address (any alignment), right-justified store data
//   resp_valid            one-cycle completion pulse
//   resp_rdata            extended load data, held until the next load completes
//   resp_error            range error, qualified by resp_valid
//   mem_raddress          memory read address
//   mem_waddress          memory write address
//   mem_data_in           memory write data
//   mem_data_out          memory read data
//   mem_write             memory write enable
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for a request; req_ready high
// RD_WAIT | reading memory; counter runs 0..MEM_RD_LAT-1, data sampled at end
// WRITE   | one-cycle full 64-bit memory write of merge_q
// DONE    | resp_valid pulse, then back to IDLE

module mem_access_unit #(
  parameter int MEM_RD_LAT = 1,
  parameter int ADDR_BITS  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_error,
  output logic [63:0] mem_raddress,
  output logic [63:0] mem_waddress,
  output logic [63:0] mem_data_in,
  input  logic [63:0] mem_data_out,
  output logic        mem_write
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [1:0] CNT_LAST = 2'(MEM_RD_LAT - 1);

`ifdef MEM_ACCESS_ADDR_CHECK_EN
  localparam bit ADDR_CHECK = 1'b1;
`else
  localparam bit ADDR_CHECK = 1'b0;
`endif

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [63:0] addr_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic        write_q;
  logic [63:0] wdata_q;
  logic [63:0] merge_q;
  logic [63:0] rdata_q;
  logic        err_q;

  logic        accept;
  logic        rd_sample;
  logic        addr_bad;
  logic [ADDR_BITS:0] end_addr;

  function automatic logic [3:0] size_bytes(input logic [1:0] size);
    case (size)
      2'b00:   size_bytes = 4'd1;
      2'b01:   size_bytes = 4'd2;
      2'b10:   size_bytes = 4'd4;
      default: size_bytes = 4'd8;
    endcase
  endfunction

  function automatic logic [63:0] lane_mask(input logic [1:0] size);
    case (size)
      2'b00:   lane_mask = 64'h0000_0000_0000_00FF;
      2'b01:   lane_mask = 64'h0000_0000_0000_FFFF;
      2'b10:   lane_mask = 64'h0000_0000_FFFF_FFFF;
      default: lane_mask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

  function automatic logic [63:0] extend(input logic [63:0] data,
                                         input logic [1:0]  size,
                                         input logic        uns);
    case (size)
      2'b00:   extend = {{56{data[7]  & ~uns}}, data[7:0]};
      2'b01:   extend = {{48{data[15] & ~uns}}, data[15:0]};
      2'b10:   extend = {{32{data[31] & ~uns}}, data[31:0]};
      default: extend = data;
    endcase
  endfunction

  // The range check uses one extra bit so that an access ending exactly at
  // the top of memory (end == 2^ADDR_BITS) is still legal.
  always_comb begin
    end_addr = {1'b0, req_addr[ADDR_BITS-1:0]}
             + {{(ADDR_BITS-3){1'b0}}, size_bytes(req_size)};
    addr_bad = ADDR_CHECK &&
               ((|req_addr[63:ADDR_BITS]) ||
                (end_addr > {1'b1, {ADDR_BITS{1'b0}}}));
  end

  assign accept    = req_valid && req_ready;
  assign rd_sample = (state_q == RD_WAIT) && (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = 2'd0;
        if (accept) begin
          if (addr_bad)
            state_d = DONE;
          else if (req_write && (req_size == 2'b11))
            state_d = WRITE;
          else
            state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = 2'd0;
          state_d = write_q ? WRITE : DONE;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      WRITE:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q  <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      write_q <= 1'b0;
      wdata_q <= '0;
      merge_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        addr_q  <= req_addr;
        size_q  <= req_size;
        uns_q   <= req_unsigned;
        write_q <= req_write;
        wdata_q <= req_wdata;
        err_q   <= addr_bad;
        // A double store needs no read, so its write data is ready at once.
        if (req_write && (req_size == 2'b11))
          merge_q <= req_wdata;
      end
      if (rd_sample) begin
        if (write_q)
          merge_q <= (mem_data_out & ~lane_mask(size_q)) |
                     (wdata_q & lane_mask(size_q));
        else
          rdata_q <= extend(mem_data_out, size_q, uns_q);
      end
    end
  end

  // rst_n gates these outputs directly, so a reset that arrives mid
  // read-modify-write cannot leak a write or a response in that cycle.
  assign req_ready    = (state_q == IDLE) && rst_n;
  assign resp_valid   = (state_q == DONE) && rst_n;
  assign resp_error   = resp_valid && err_q;
  assign resp_rdata   = rdata_q;
  assign mem_raddress = addr_q;
  assign mem_waddress = addr_q;
  assign mem_data_in  = merge_q;
  assign mem_write    = (state_q == WRITE) && rst_n;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
  localparam int L   = 1;
  localparam int AB  = 16;
  localparam int MSZ = 1 << AB;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_error;
  logic [63:0] mem_raddress;
  logic [63:0] mem_waddress;
  logic [63:0] mem_data_in;
  logic [63:0] mem_data_out;
  logic        mem_write;

  always #5 clk = ~clk;

  mem_access_unit #(.MEM_RD_LAT(L), .ADDR_BITS(AB)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_error(resp_error), .mem_raddress(mem_raddress),
    .mem_waddress(mem_waddress), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out), .mem_write(mem_write)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] init_byte(input int i);
    logic [63:0] k;
    k = 64'h1122_3344_5566_7788;
    if (i == 'h10) return 8'h80;
    if (i == 'h11) return 8'hFF;
    if (i >= 'h12 && i <= 'h17) return 8'h00;
    if (i >= 'h20 && i <= 'h27) return k[8*(i-'h20) +: 8];
    return 8'((i * 37) ^ (i >> 8) ^ 8'h5A);
  endfunction

  // Memory seen by the DUT: wraps modulo 2^AB, readable L cycles after address.
  logic [7:0]  mem [MSZ];
  logic [63:0] rd_comb;
  logic [63:0] dly [0:3];

  always_comb begin
    rd_comb = '0;
    for (int i = 0; i < 8; i++)
      rd_comb[8*i +: 8] = mem[mem_raddress[AB-1:0] + AB'(i)];
  end

  always @(posedge clk) begin
    dly[0] <= rd_comb;
    for (int i = 1; i < 4; i++) dly[i] <= dly[i-1];
  end

  assign mem_data_out = (L == 1) ? rd_comb : dly[(L >= 2) ? L - 2 : 0];

  initial begin
    for (int i = 0; i < MSZ; i++) mem[i] = init_byte(i);
    forever begin
      @(posedge clk);
      if (mem_write)
        for (int i = 0; i < 8; i++)
          mem[mem_waddress[AB-1:0] + AB'(i)] <= mem_data_in[8*i +: 8];
    end
  end

  // Reference model state (owned by the driver).
  logic [7:0]  ref_mem [MSZ];
  int          acc_cyc  = -100;
  int          wr_cyc   = -100;
  int          resp_cyc = -100;
  logic [63:0] exp_wdata = '0;
  logic [63:0] exp_addr  = '0;
  logic        cur_load  = 1'b0;
  logic        cur_err   = 1'b0;
  logic [63:0] rdata_hold = '0;
  logic [63:0] rdata_new  = '0;
  bit          check_en   = 1'b0;

  function automatic logic [63:0] exp_rdata();
    return (cur_load && !cur_err && cyc >= resp_cyc) ? rdata_new : rdata_hold;
  endfunction

  function automatic logic [63:0] ref_load(input logic [15:0] a, input int n,
                                          input logic uns);
    logic [63:0] v;
    logic        fill;
    v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[a + 16'(i)];
    fill = !uns && ref_mem[a + 16'(n - 1)][7];
    for (int i = n; i < 8; i++) v[8*i +: 8] = fill ? 8'hFF : 8'h00;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Per-cycle compare against the model.
  initial forever begin
    @(negedge clk);
    #1;
    if (check_en) begin
      chk("req_ready", req_ready, !(cyc > acc_cyc && cyc <= resp_cyc));
      chk("resp_valid", resp_valid, cyc == resp_cyc);
      chk("resp_error", resp_error, (cyc == resp_cyc) && cur_err);
      chk("mem_write", mem_write, cyc == wr_cyc);
      if (cyc == wr_cyc) begin
        chk("mem_data_in", mem_data_in, exp_wdata);
        chk("mem_waddress", mem_waddress, exp_addr);
      end
      if (cyc > acc_cyc && cyc <= resp_cyc)
        chk("mem_raddress", mem_raddress, exp_addr);
      chk("resp_rdata", resp_rdata, exp_rdata());
    end
  end

  task automatic do_req(input logic w, input logic [1:0] sz, input logic uns,
                        input logic [63:0] addr, input logic [63:0] wd,
                        input int gap);
    int          t, n;
    logic [15:0] a;
    logic [63:0] mrg;
    logic        err;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    t = (cyc > resp_cyc) ? cyc : resp_cyc + 1;
    while (cyc < t) @(negedge clk);
    n   = 1 << sz;
    a   = addr[15:0];
    err = 1'b0;
`ifdef MEM_ACCESS_ADDR_CHECK_EN
    err = (addr[63:AB] != '0) || (int'(a) + n > MSZ);
`endif
    rdata_hold = exp_rdata();
    acc_cyc  = t;
    exp_addr = addr;
    cur_err  = err;
    cur_load = !w;
    if (err) begin
      wr_cyc = -100; resp_cyc = t + 1;
    end else if (!w) begin
      rdata_new = ref_load(a, n, uns);
      wr_cyc = -100; resp_cyc = t + L + 1;
    end else begin
      for (int i = 0; i < 8; i++) mrg[8*i +: 8] = ref_mem[a + 16'(i)];
      for (int i = 0; i < n; i++) begin
        mrg[8*i +: 8] = wd[8*i +: 8];
        ref_mem[a + 16'(i)] = wd[8*i +: 8];
      end
      exp_wdata = mrg;
      wr_cyc    = (sz == 2'b11) ? t + 1 : t + L + 1;
      resp_cyc  = wr_cyc + 1;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic at_cycle(input int c);
    while (cyc < c) @(negedge clk);
    #2;
  endtask

  task automatic wait_idle();
    while (cyc <= resp_cyc) @(negedge clk);
    #2;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] addr, wd;
    logic [15:0] a16;
    int          mism, t;
    for (int i = 0; i < MSZ; i++) ref_mem[i] = init_byte(i);

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_req_ready", req_ready, 1'b0);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_mem_write", mem_write, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_resp_rdata", resp_rdata, 64'h0);
    chk("rst_resp_error", resp_error, 1'b0);
    chk("rst_ready_after", req_ready, 1'b1);
    check_en = 1'b1;

    // Load extension
    do_req(1'b0, 2'b00, 1'b0, 64'h10, '0, 0);
    at_cycle(acc_cyc + L + 1);
    chk("lb_resp_valid_lit", resp_valid, 1'b1);
    chk("lb_lit", resp_rdata, 64'hFFFF_FFFF_FFFF_FF80);
    do_req(1'b0, 2'b00, 1'b1, 64'h10, '0, 0);
    wait_idle();
    chk("lbu_lit", resp_rdata, 64'h80);
    do_req(1'b0, 2'b01, 1'b0, 64'h10, '0, 0);
    wait_idle();
    chk("lh_lit", resp_rdata, 64'hFFFF_FFFF_FFFF_FF80);

    // Partial store RMW
    do_req(1'b1, 2'b01, 1'b0, 64'h20, 64'hDEAD_BEEF, 0);
    at_cycle(acc_cyc + L + 1);
    chk("sh_write_lit", mem_write, 1'b1);
    chk("sh_data_lit", mem_data_in, 64'h1122_3344_5566_BEEF);
    at_cycle(acc_cyc + L + 2);
    chk("sh_resp_lit", resp_valid, 1'b1);
    chk("sh_rdata_kept_lit", resp_rdata, 64'hFFFF_FFFF_FFFF_FF80);

    // Double store fast path
    do_req(1'b1, 2'b11, 1'b0, 64'h8, 64'h0123_4567_89AB_CDEF, 0);
    at_cycle(acc_cyc + 1);
    chk("sd_write_lit", mem_write, 1'b1);
    at_cycle(acc_cyc + 2);
    chk("sd_resp_lit", resp_valid, 1'b1);
    do_req(1'b0, 2'b11, 1'b0, 64'h8, '0, 0);
    wait_idle();
    chk("ld_lit", resp_rdata, 64'h0123_4567_89AB_CDEF);

    // Unaligned word with wrap
    do_req(1'b1, 2'b10, 1'b0, 64'hFFFE, 64'h5555_6666_AABB_CCDD, 1);
    wait_idle();
    chk("sw_wrap_lit", {32'h0, mem[16'h0001], mem[16'h0000], mem[16'hFFFF],
                        mem[16'hFFFE]}, 64'hAABB_CCDD);
    do_req(1'b0, 2'b10, 1'b1, 64'hFFFE, '0, 0);
    wait_idle();
    chk("lwu_wrap_lit", resp_rdata, 64'hAABB_CCDD);

`ifdef MEM_ACCESS_ADDR_CHECK_EN
    do_req(1'b0, 2'b11, 1'b0, 64'h1_0000, '0, 0);
    at_cycle(acc_cyc + 1);
    chk("err_resp_lit", resp_valid, 1'b1);
    chk("err_flag_lit", resp_error, 1'b1);
    do_req(1'b1, 2'b00, 1'b0, 64'hFFFF, 64'h42, 0);
    wait_idle();
`endif

    // Reset in the middle of a read-modify-write
    wait_idle();
    @(negedge clk);
    check_en = 1'b0;
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 64'h30; req_wdata = 64'h77;
    t = cyc;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rmw_rst_write", mem_write, 1'b0);
    chk("rmw_rst_resp", resp_valid, 1'b0);
    chk("rmw_rst_ready", req_ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rmw_ready_after", req_ready, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      chk("rmw_no_write", mem_write, 1'b0);
      chk("rmw_no_resp", resp_valid, 1'b0);
    end
    chk("rmw_mem_kept", mem[16'h30], ref_mem[16'h30]);
    chk("rmw_rdata_cleared", resp_rdata, 64'h0);
    if (cyc < t) chk("rmw_cycle_order", cyc, t);
    acc_cyc = -100; wr_cyc = -100; resp_cyc = -100;
    cur_load = 1'b0; cur_err = 1'b0; rdata_hold = '0;
    check_en = 1'b1;

    // Random traffic
    for (int k = 0; k < 300; k++) begin
      a16 = 16'($urandom());
      if ($urandom_range(0, 3) == 0) a16 = 16'hFFF8 | 16'($urandom_range(0, 7));
      addr = {48'h0, a16};
      if ($urandom_range(0, 7) == 0) addr[63:16] = 48'({$urandom(), $urandom()});
      wd = {$urandom(), $urandom()};
      do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), addr, wd, $urandom_range(0, 3));
    end
    wait_idle();
    repeat (2) @(negedge clk);

    mism = 0;
    for (int i = 0; i < MSZ; i++) if (mem[i] !== ref_mem[i]) mism++;
    chk("mem_final", 64'(mism), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
